// File: rtl/audio_frame_ctrl.sv
// audio_frame_ctrl: gates raw audio into the pre-emphasis filter, captures the
// filtered result one cycle later into a circular buffer, and streams
// overlapping frames of FRAME_LEN samples (advancing by HOP) over valid/ready.
// Optional build macro: AFC_FRAME_COUNT_EN adds the frame_count[15:0] output.
module audio_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 32,
  parameter int HOP        = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic                  audio_valid,
  output logic [DATA_WIDTH-1:0] pe_sample_o,
  output logic                  pe_valid_o,
  input  logic [DATA_WIDTH-1:0] pe_data_i,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  frame_first,
  output logic                  frame_last,
  output logic                  overflow,
  output logic                  busy
`ifdef AFC_FRAME_COUNT_EN
  ,
  output logic [15:0]           frame_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FLEN_A   = (ADDR_WIDTH+1)'(FRAME_LEN);
  localparam logic [ADDR_WIDTH:0]   HOP_A    = (ADDR_WIDTH+1)'(HOP);
  localparam logic [ADDR_WIDTH:0]   AVAIL_Z  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] HOP_P    = ADDR_WIDTH'(HOP);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_P    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_Z    = {ADDR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_STREAM  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   base_ptr_q, base_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_WIDTH:0]     avail_q, avail_d;
  logic                    cap_pend_q;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   frame_data_q, frame_data_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_first_q, frame_first_d;
  logic                    frame_last_q, frame_last_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    cap_s, full_s, wr_en_s, drop_s;
  logic                    xfer_s, last_xfer_s;
  logic [ADDR_WIDTH:0]     avail_nxt_s;
  logic [ADDR_WIDTH-1:0]   rd_cur_s, rd_nxt_s, rd_hop_s;

  assign pe_sample_o = audio_in;
  assign pe_valid_o  = audio_valid & en & (state_q != ST_IDLE);

  // A capture is one cycle behind the filter strobe; IDLE never captures.
  assign cap_s   = cap_pend_q & (state_q != ST_IDLE);
  assign full_s  = (avail_q == DEPTH_A);
  assign wr_en_s = cap_s & ~full_s;
  assign drop_s  = cap_s & full_s;

  assign xfer_s      = (state_q == ST_STREAM) & frame_valid_q & frame_ready;
  assign last_xfer_s = xfer_s & (rd_idx_q == LAST_IDX);

  // Occupancy after this cycle: capture and frame retire may coincide.
  assign avail_nxt_s = avail_q + {{ADDR_WIDTH{1'b0}}, wr_en_s}
                       - (last_xfer_s ? HOP_A : AVAIL_Z);

  assign rd_cur_s = base_ptr_q + rd_idx_q;
  assign rd_nxt_s = rd_cur_s + ONE_P;
  assign rd_hop_s = base_ptr_q + HOP_P;

  // Next-state, pointer bookkeeping and registered frame output selection.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_en_s ? (wr_ptr_q + ONE_P) : wr_ptr_q;
    base_ptr_d    = base_ptr_q;
    rd_idx_d      = rd_idx_q;
    avail_d       = avail_nxt_s;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_first_d = frame_first_q;
    frame_last_d  = frame_last_q;
    overflow_d    = overflow_q;

    case (state_q)
      ST_IDLE: begin
        wr_ptr_d      = PTR_Z;
        base_ptr_d    = PTR_Z;
        rd_idx_d      = PTR_Z;
        avail_d       = AVAIL_Z;
        frame_valid_d = 1'b0;
        frame_first_d = 1'b0;
        frame_last_d  = 1'b0;
        if (en) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (avail_q >= FLEN_A) begin
          state_d  = ST_STREAM;
          rd_idx_d = PTR_Z;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_STREAM: begin
        if (!frame_valid_q) begin
          // Entry cycle: present the beat at rd_idx.
          frame_data_d  = mem_q[rd_cur_s];
          frame_valid_d = 1'b1;
          frame_first_d = (rd_idx_q == PTR_Z);
          frame_last_d  = (rd_idx_q == LAST_IDX);
        end else if (frame_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            base_ptr_d = rd_hop_s;
            rd_idx_d   = PTR_Z;
            if (en && (avail_nxt_s >= FLEN_A)) begin
              // Next frame is already complete: keep valid high, no bubble.
              state_d       = ST_STREAM;
              frame_data_d  = mem_q[rd_hop_s];
              frame_valid_d = 1'b1;
              frame_first_d = 1'b1;
              frame_last_d  = 1'b0;
            end else begin
              state_d       = en ? ST_COLLECT : ST_IDLE;
              frame_valid_d = 1'b0;
              frame_first_d = 1'b0;
              frame_last_d  = 1'b0;
            end
          end else begin
            rd_idx_d      = rd_idx_q + ONE_P;
            frame_data_d  = mem_q[rd_nxt_s];
            frame_valid_d = 1'b1;
            frame_first_d = 1'b0;
            frame_last_d  = ((rd_idx_q + ONE_P) == LAST_IDX);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        frame_valid_d = 1'b0;
        frame_first_d = 1'b0;
        frame_last_d  = 1'b0;
      end
    endcase

    if (state_d == ST_IDLE) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q | drop_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= PTR_Z;
      base_ptr_q    <= PTR_Z;
      rd_idx_q      <= PTR_Z;
      avail_q       <= AVAIL_Z;
      cap_pend_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frame_data_q  <= {DATA_WIDTH{1'b0}};
      frame_valid_q <= 1'b0;
      frame_first_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      base_ptr_q    <= base_ptr_d;
      rd_idx_q      <= rd_idx_d;
      avail_q       <= avail_d;
      cap_pend_q    <= pe_valid_o;
      overflow_q    <= overflow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_first_q <= frame_first_d;
      frame_last_q  <= frame_last_d;
    end
  end

  // Sample buffer write port; storage itself is not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= pe_data_i;
    end
  end

`ifdef AFC_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Completed-frame counter, held at zero while idle.
  always_comb begin
    if (state_d == ST_IDLE) begin
      frame_count_d = 16'd0;
    end else if (last_xfer_s) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_first = frame_first_q;
  assign frame_last  = frame_last_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_frame_ctrl.sv
// Bench for audio_frame_ctrl: a 1-cycle pre-emphasis filter model feeds the
// DUT, and a sample-index reference model predicts every frame beat.
module tb_audio_frame_ctrl;
  localparam int DW    = 16;
  localparam int FL    = 32;
  localparam int HOP   = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n, en, audio_valid, frame_ready;
  logic [DW-1:0] audio_in, pe_data_i;
  logic [DW-1:0] pe_sample_o, frame_data;
  logic          pe_valid_o, frame_valid, frame_first, frame_last, overflow, busy;
`ifdef AFC_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  audio_frame_ctrl #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .HOP(HOP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .audio_in(audio_in), .audio_valid(audio_valid),
    .pe_sample_o(pe_sample_o), .pe_valid_o(pe_valid_o), .pe_data_i(pe_data_i),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_first(frame_first), .frame_last(frame_last), .overflow(overflow), .busy(busy)
`ifdef AFC_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] caps[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          frames_seen = 0;
  int          frames_exp = 0;
  int          next_start = 0;
  logic        exp_ovf = 1'b0;
  int          ready_mode = 2;
  int          rp = 0;
  logic        gate_on = 1'b0;
  logic        acc_q = 1'b0;
  logic [15:0] acc_x = 16'd0;
  logic [15:0] flt_prev = 16'd0;
  logic        stall_prev = 1'b0;
  logic        gap_prev = 1'b0;
  logic [15:0] stall_data = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    caps.delete();
    frames_seen = 0;
    frames_exp  = 0;
    next_start  = 0;
    exp_ovf     = 1'b0;
  endtask

  // Filtered sample n of the current run; frame f is samples f*HOP .. f*HOP+FL-1.
  task automatic model_push(input logic [15:0] y);
    int retained;
    retained = caps.size() - frames_seen * HOP;
    if (retained >= DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      caps.push_back(y);
      while (caps.size() >= next_start + FL) begin
        for (int b = 0; b < FL; b++) begin
          exp_q.push_back('{data: caps[next_start + b], first: (b == 0), last: (b == FL - 1)});
        end
        next_start += HOP;
        frames_exp++;
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    if (stall_prev) begin
      chk("stall_valid", 32'(frame_valid), 32'd1);
      chk("stall_data", 32'(frame_data), 32'(stall_data));
    end
    if (gap_prev) chk("no_bubble", 32'(frame_valid), 32'd1);
    gap_prev = 1'b0;
    if (frame_valid && frame_ready) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(frame_data), 32'(e.data));
        chk("beat_first", 32'(frame_first), 32'(e.first));
        chk("beat_last", 32'(frame_last), 32'(e.last));
        if (e.last) begin
          frames_seen++;
          gap_prev = en && (exp_q.size() != 0);
        end else begin
          gap_prev = 1'b1;
        end
      end
    end
    stall_prev = frame_valid && !frame_ready;
    stall_data = frame_data;
  endtask

  // One clock: entered at posedge+1, drives inputs, checks at negedge.
  task automatic step(input logic v, input logic [15:0] x);
    logic [15:0] y;
    if (acc_q) begin
      y = acc_x - (flt_prev >> 1);
      flt_prev = acc_x;
      pe_data_i = y;
      model_push(y);
    end else begin
      pe_data_i = 16'($urandom);
    end
    audio_valid = v;
    audio_in    = x;
    case (ready_mode)
      0:       frame_ready = 1'b1;
      1:       frame_ready = (rp == 0) || (rp == 3);
      default: frame_ready = 1'b0;
    endcase
    rp    = (rp + 1) % 4;
    acc_q = v & en & gate_on;
    acc_x = x;
    @(negedge clk);
    chk("pe_valid", 32'(pe_valid_o), 32'(v & en & gate_on));
    chk("pe_sample", 32'(pe_sample_o), 32'(x));
    if (rst_n) begin
      monitor();
    end else begin
      stall_prev = 1'b0;
      gap_prev   = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int gmin, input int gmax, input logic ramp, input int k0);
    logic [15:0] x;
    int g;
    for (int k = 0; k < n; k++) begin
      x = ramp ? 16'((k0 + k) * 256) : 16'($urandom);
      step(1'b1, x);
      g = int'($urandom_range(gmax, gmin));
      for (int i = 1; i < g; i++) step(1'b0, 16'($urandom));
    end
  endtask

  task automatic start_test(input int mode);
    model_clear();
    ready_mode = mode;
    rp = 0;
    en = 1'b1;
    step(1'b0, 16'd0);
    step(1'b0, 16'd0);
    chk("busy_on", 32'(busy), 32'd1);
    gate_on = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || acc_q) && n < budget) begin
      step(1'b0, 16'($urandom));
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'($urandom));
  endtask

  task automatic end_test();
    chk("frames_vs_model", 32'(frames_seen), 32'(frames_exp));
    chk("overflow_vs_model", 32'(overflow), 32'(exp_ovf));
    en = 1'b0;
    gate_on = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_overflow", 32'(overflow), 32'd0);
    chk("idle_valid", 32'(frame_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; audio_valid = 1'b1; audio_in = 16'h1234;
    pe_data_i = 16'd0; frame_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_first", 32'(frame_first), 32'd0);
    chk("rst_last", 32'(frame_last), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(frame_data), 32'd0);
    chk("rst_pe_valid", 32'(pe_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 16'h00aa);
    step(1'b0, 16'h0000);
    chk("idle_after_rst", 32'(busy), 32'd0);

    // First frame: ramp samples every 4 cycles, then 16 more for the overlap.
    start_test(0);
    send(32, 4, 4, 1'b1, 0);
    drain("drain_first", 400);
    chk("first_frames", 32'(frames_seen), 32'd1);
    send(16, 4, 4, 1'b1, 32);
    drain("drain_overlap", 400);
    chk("overlap_frames", 32'(frames_seen), 32'd2);
    end_test();

    // Backpressure: ready pattern 1,0,0,1.
    start_test(1);
    send(80, 4, 4, 1'b0, 0);
    drain("drain_bp", 3000);
    chk("bp_frames", 32'(frames_seen), 32'd4);
    end_test();

    // Overflow: ready low while 65 samples arrive.
    start_test(2);
    send(65, 2, 2, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_model", 32'(exp_ovf), 32'd1);
    chk("ovf_valid_held", 32'(frame_valid), 32'd1);
    ready_mode = 0;
    drain("drain_ovf", 1000);
    chk("ovf_frames", 32'(frames_seen), 32'd3);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    end_test();

    // Wrap: 200 samples, ready always high.
    start_test(0);
    send(200, 2, 3, 1'b0, 0);
    drain("drain_wrap", 1000);
    chk("wrap_frames", 32'(frames_seen), 32'd11);
    end_test();

    // Reset asserted in the middle of a frame.
    start_test(0);
    send(34, 2, 2, 1'b0, 0);
    n = 0;
    while (!frame_valid && n < 100) begin
      step(1'b0, 16'd0);
      n++;
    end
    chk("mid_stream_seen", 32'(frame_valid), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(frame_valid), 32'd0);
    chk("mrst_first", 32'(frame_first), 32'd0);
    chk("mrst_last", 32'(frame_last), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_overflow", 32'(overflow), 32'd0);
    chk("mrst_data", 32'(frame_data), 32'd0);
    en = 1'b0;
    gate_on = 1'b0;
    acc_q = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom));
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(frame_valid), 32'd0);
    chk("post_rst_last", 32'(frame_last), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
